// File: rtl/button_event_pkg.sv
// Shared state type and elaboration-time helpers for the push-button event decoder.
package button_event_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRESS1,
        ST_WAIT2,
        ST_PRESS2,
        ST_LONG
    } state_e;

    function automatic int cycles_per_ms(input int clk_freq);
        return clk_freq / 1000;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: tick_o is high for one cycle every CyclesPerMs cycles,
// phase-aligned to the most recent clear_i.
module ms_tick_gen #(
    parameter int CyclesPerMs = 100_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    output logic tick_o
);

    localparam int PW = $clog2(CyclesPerMs);
    localparam logic [PW-1:0] Last = PW'(CyclesPerMs - 1);

    logic [PW-1:0] presc_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            presc_q <= '0;
        end else if (presc_q == Last) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    assign tick_o = (presc_q == Last);

endmodule

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into short / double / long / repeat pulses.
// state     | meaning
// ST_IDLE   | button released, nothing pending
// ST_PRESS1 | first press held, timing toward long press
// ST_WAIT2  | first press released, waiting for a second click
// ST_PRESS2 | second press held, double click unless held long
// ST_LONG   | long press in progress, auto-repeat running
module button_event_decoder
    import button_event_pkg::*;
#(
    parameter int ClkFreq       = 100_000_000,
    parameter int LongPressMs   = 800,
    parameter int DoubleClickMs = 250,
    parameter int RepeatMs      = 100,
    parameter bit RepeatEn      = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic level_i,
    output logic short_o,
    output logic double_o,
    output logic long_o,
    output logic repeat_o,
    output logic busy_o
);

    localparam int Cpm   = cycles_per_ms(ClkFreq);
    localparam int MaxMs = max3(LongPressMs, DoubleClickMs, RepeatMs);
    localparam int MsW   = $clog2(MaxMs + 1);

    // Expiry fires on the tick that completes the final millisecond.
    localparam logic [MsW-1:0] LongLast   = MsW'(LongPressMs - 1);
    localparam logic [MsW-1:0] DoubleLast = MsW'(DoubleClickMs - 1);
    localparam logic [MsW-1:0] RepeatLast = MsW'(RepeatMs - 1);

    state_e         state_q, state_d;
    logic           level_q;
    logic           rise, fall;
    logic           tick, timer_clear, restart;
    logic [MsW-1:0] ms_q;
    logic           long_exp, dbl_exp, rep_exp;
    logic           short_d, double_d, long_d, repeat_d;

    assign rise = level_i & ~level_q;
    assign fall = ~level_i & level_q;

    ms_tick_gen #(.CyclesPerMs(Cpm)) u_tick (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (timer_clear),
        .tick_o  (tick)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i || timer_clear) begin
            ms_q <= '0;
        end else if (tick && (ms_q != '1)) begin
            ms_q <= ms_q + 1'b1;
        end
    end

    assign long_exp = tick && (ms_q == LongLast);
    assign dbl_exp  = tick && (ms_q == DoubleLast);
    assign rep_exp  = tick && (ms_q == RepeatLast);

    // Edges are tested first so they win over a coincident timer expiry.
    always_comb begin
        state_d  = state_q;
        short_d  = 1'b0;
        double_d = 1'b0;
        long_d   = 1'b0;
        repeat_d = 1'b0;
        restart  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (rise) state_d = ST_PRESS1;
            end
            ST_PRESS1: begin
                if (fall) begin
                    state_d = ST_WAIT2;
                end else if (long_exp) begin
                    long_d  = 1'b1;
                    state_d = ST_LONG;
                end
            end
            ST_WAIT2: begin
                if (rise) begin
                    state_d = ST_PRESS2;
                end else if (dbl_exp) begin
                    short_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_PRESS2: begin
                if (fall) begin
                    double_d = 1'b1;
                    state_d  = ST_IDLE;
                end else if (long_exp) begin
                    long_d  = 1'b1;
                    state_d = ST_LONG;
                end
            end
            ST_LONG: begin
                if (fall) begin
                    state_d = ST_IDLE;
                end else if (rep_exp) begin
                    repeat_d = RepeatEn;
                    restart  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign timer_clear = (state_d != state_q) || restart;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            level_q  <= 1'b0;
            short_o  <= 1'b0;
            double_o <= 1'b0;
            long_o   <= 1'b0;
            repeat_o <= 1'b0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_i;
            short_o  <= short_d;
            double_o <= double_d;
            long_o   <= long_d;
            repeat_o <= repeat_d;
        end
    end

    assign busy_o = (state_q != ST_IDLE);

endmodule

// File: tb/tb_button_event_decoder.sv
// Bench for button_event_decoder: level sequences are decoded by a press/gap
// duration model and compared every cycle against two DUTs (repeat on / off).
module tb_button_event_decoder;

    localparam int Cpm  = 10;
    localparam int L    = 5 * Cpm;
    localparam int D    = 3 * Cpm;
    localparam int R    = 2 * Cpm;
    localparam int MaxN = 1200;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic level = 1'b0;
    logic short_a, double_a, long_a, repeat_a, busy_a;
    logic short_b, double_b, long_b, repeat_b, busy_b;

    always #5 clk = ~clk;

    button_event_decoder #(
        .ClkFreq(10_000), .LongPressMs(5), .DoubleClickMs(3), .RepeatMs(2), .RepeatEn(1'b1)
    ) u_dut (
        .clk_i(clk), .rst_i(rst), .level_i(level),
        .short_o(short_a), .double_o(double_a), .long_o(long_a),
        .repeat_o(repeat_a), .busy_o(busy_a)
    );

    button_event_decoder #(
        .ClkFreq(10_000), .LongPressMs(5), .DoubleClickMs(3), .RepeatMs(2), .RepeatEn(1'b0)
    ) u_dut_norep (
        .clk_i(clk), .rst_i(rst), .level_i(level),
        .short_o(short_b), .double_o(double_b), .long_o(long_b),
        .repeat_o(repeat_b), .busy_o(busy_b)
    );

    bit lvl[MaxN];
    bit ex_short[MaxN], ex_double[MaxN], ex_long[MaxN], ex_rep[MaxN], ex_busy[MaxN];
    int nlen;
    int n_vec = 0;
    int n_err = 0;
    int ep = 0;
    int cyc = 0;

    task automatic check_val(input string tag, input logic obs, input logic exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s ep%0d cyc%0d: got %b want %b", tag, ep, cyc, obs, exp);
        end
    endtask

    task automatic add_seg(input bit v, input int len);
        for (int i = 0; i < len; i++) begin
            if (nlen < MaxN) begin
                lvl[nlen] = v;
                nlen++;
            end
        end
    endtask

    function automatic int run_end(input int from, input bit v);
        int i;
        i = from;
        while (i < nlen && lvl[i] == v) i++;
        return i;
    endfunction

    task automatic mark_busy(input int a, input int b);
        for (int i = a; i < b && i < nlen; i++) ex_busy[i] = 1'b1;
    endtask

    // Press held past the long threshold: long at s+L, repeats every R until the release.
    task automatic mark_held(input int s, input int f);
        ex_long[s + L] = 1'b1;
        for (int k = s + L + R; k < f; k += R) ex_rep[k] = 1'b1;
    endtask

    task automatic build_expect();
        int t, s, f, s2, f2;
        for (int i = 0; i < MaxN; i++) begin
            ex_short[i] = 1'b0; ex_double[i] = 1'b0; ex_long[i] = 1'b0;
            ex_rep[i] = 1'b0;   ex_busy[i] = 1'b0;
        end
        t = 0;
        while (t < nlen) begin
            if (!lvl[t]) begin
                t++;
                continue;
            end
            s = t;
            f = run_end(s, 1'b1);
            if (f - s > L) begin
                mark_held(s, f); mark_busy(s, f); t = f;
                continue;
            end
            if (f >= nlen) begin
                mark_busy(s, nlen);
                break;
            end
            s2 = run_end(f, 1'b0);
            if (s2 - f > D) begin
                ex_short[f + D] = 1'b1; mark_busy(s, f + D); t = s2;
                continue;
            end
            if (s2 >= nlen) begin
                mark_busy(s, nlen);
                break;
            end
            f2 = run_end(s2, 1'b1);
            if (f2 - s2 > L) begin
                mark_held(s2, f2); mark_busy(s, f2); t = f2;
                continue;
            end
            if (f2 >= nlen) begin
                mark_busy(s, nlen);
                break;
            end
            ex_double[f2] = 1'b1; mark_busy(s, f2); t = f2;
        end
    endtask

    // Entered and left on a falling clock edge.
    task automatic run_episode();
        build_expect();
        cyc = -1;
        rst = 1'b1;
        level = lvl[0];
        @(posedge clk); #1;
        check_val("rst_short",  short_a,  1'b0);
        check_val("rst_double", double_a, 1'b0);
        check_val("rst_long",   long_a,   1'b0);
        check_val("rst_repeat", repeat_a, 1'b0);
        check_val("rst_busy",   busy_a,   1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int e = 0; e < nlen; e++) begin
            cyc = e;
            level = lvl[e];
            @(posedge clk); #1;
            check_val("short",  short_a,  ex_short[e]);
            check_val("double", double_a, ex_double[e]);
            check_val("long",   long_a,   ex_long[e]);
            check_val("repeat", repeat_a, ex_rep[e]);
            check_val("busy",   busy_a,   ex_busy[e]);
            check_val("norep_short",  short_b,  ex_short[e]);
            check_val("norep_double", double_b, ex_double[e]);
            check_val("norep_long",   long_b,   ex_long[e]);
            check_val("norep_repeat", repeat_b, 1'b0);
            check_val("norep_busy",   busy_b,   ex_busy[e]);
            @(negedge clk);
        end
        ep++;
    endtask

    function automatic int pick_press();
        case ($urandom_range(0, 5))
            0: return L;
            1: return L - 1;
            2: return L + 1;
            3: return $urandom_range(1, L + 60);
            4: return $urandom_range(1, 15);
            default: return L + R * $urandom_range(1, 3);
        endcase
    endfunction

    function automatic int pick_gap();
        case ($urandom_range(0, 4))
            0: return D;
            1: return D - 1;
            2: return D + 1;
            3: return $urandom_range(1, D + 20);
            default: return $urandom_range(1, 10);
        endcase
    endfunction

    initial begin
        @(negedge clk);

        nlen = 0; add_seg(1'b1, 20); add_seg(1'b0, 60); run_episode();
        nlen = 0; add_seg(1'b1, 20); add_seg(1'b0, 15); add_seg(1'b1, 20); add_seg(1'b0, 40); run_episode();
        nlen = 0; add_seg(1'b1, 100); add_seg(1'b0, 40); run_episode();
        nlen = 0; add_seg(1'b1, 50); add_seg(1'b0, 60); run_episode();
        nlen = 0; add_seg(1'b1, 20); add_seg(1'b0, 30); add_seg(1'b1, 20); add_seg(1'b0, 40); run_episode();
        // Truncated in WAIT2; the next episode's reset must drop the pending short.
        nlen = 0; add_seg(1'b1, 20); add_seg(1'b0, 10); run_episode();
        nlen = 0; add_seg(1'b0, 3); add_seg(1'b1, 20); add_seg(1'b0, 60); run_episode();
        nlen = 0; add_seg(1'b1, 30); add_seg(1'b0, 50); run_episode();

        for (int k = 0; k < 40; k++) begin
            int nseg;
            nlen = 0;
            nseg = $urandom_range(2, 6);
            if ($urandom_range(0, 1) == 1) add_seg(1'b0, $urandom_range(1, 5));
            for (int j = 0; j < nseg; j++) begin
                add_seg(1'b1, pick_press());
                add_seg(1'b0, pick_gap());
            end
            add_seg(1'b0, D + 5);
            run_episode();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
